// File: rtl/video_timing_pkg.sv
// NTSC timing constants at 74.25 MHz and the shared types used by the sync separator.
package video_timing_pkg;

  localparam int NTSC_LINE_CLKS   = 4719;
  localparam int NTSC_HSYNC_CLKS  = 349;
  localparam int NTSC_EQ_CLKS     = 171;
  localparam int NTSC_BROAD_CLKS  = 2005;
  localparam int NTSC_BURST_START = 400;
  localparam int NTSC_BURST_LEN   = 180;

  localparam int DEF_SYNC_THRESH  = -1200;
  localparam int DEF_HYST         = 64;
  localparam int DEF_GLITCH_MIN   = 16;
  localparam int DEF_HSYNC_MIN    = 260;
  localparam int DEF_VSYNC_MIN    = 1500;
  localparam int DEF_LINE_MIN     = 4000;
  localparam int DEF_LINE_TIMEOUT = 5200;
  localparam int DEF_LOCK_LINES   = 4;

  localparam int LINE_TMR_W       = 13;
  localparam int LOW_CNT_W        = 11;
  localparam int LINE_CNT_W       = 10;
  localparam int BURST_MIN_LINE   = 9;
  localparam int VSYNC_REARM_LINE = 16;

  typedef logic signed [11:0] sample_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic timeout;
  } sync_evt_t;

endpackage

// File: rtl/sync_separator_if.sv
// Sample stream in, sync timing out; master is the video source/consumer side.
interface sync_separator_if;
  import video_timing_pkg::*;

  sample_t               adc_raw;
  logic                  sync_low;
  logic                  hsync_pulse;
  logic                  vsync_pulse;
  logic                  burst_active;
  logic [LINE_CNT_W-1:0] line_count;
  logic                  locked;

  modport master (
    output adc_raw,
    input  sync_low, hsync_pulse, vsync_pulse, burst_active, line_count, locked
  );

  modport slave (
    input  adc_raw,
    output sync_low, hsync_pulse, vsync_pulse, burst_active, line_count, locked
  );
endinterface

// File: rtl/sync_slicer.sv
// Hysteretic sync-tip comparator followed by a debounce filter producing the clean sync level.
module sync_slicer
  import video_timing_pkg::*;
#(
  parameter int SYNC_THRESH = DEF_SYNC_THRESH,
  parameter int HYST        = DEF_HYST,
  parameter int GLITCH_MIN  = DEF_GLITCH_MIN
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t adc_raw,
  output logic    sync_low
);

  localparam int      DBN_W   = $clog2(GLITCH_MIN + 1);
  localparam sample_t SET_LVL = sample_t'(SYNC_THRESH);
  localparam sample_t CLR_LVL = sample_t'(SYNC_THRESH + HYST);

  logic             cmp_reg, cmp_next;
  logic             sync_low_reg, sync_low_next;
  logic [DBN_W-1:0] dbn_reg, dbn_next;

  // Between the two levels the comparator holds its previous decision.
  always_comb begin
    cmp_next = cmp_reg;
    if (adc_raw < SET_LVL) begin
      cmp_next = 1'b1;
    end else if (adc_raw > CLR_LVL) begin
      cmp_next = 1'b0;
    end
  end

  always_comb begin
    sync_low_next = sync_low_reg;
    dbn_next      = '0;
    if (cmp_reg != sync_low_reg) begin
      if (dbn_reg == DBN_W'(GLITCH_MIN - 1)) begin
        sync_low_next = cmp_reg;
      end else begin
        dbn_next = dbn_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_reg      <= 1'b0;
      sync_low_reg <= 1'b0;
      dbn_reg      <= '0;
    end else begin
      cmp_reg      <= cmp_next;
      sync_low_reg <= sync_low_next;
      dbn_reg      <= dbn_next;
    end
  end

  assign sync_low = sync_low_reg;

endmodule

// File: rtl/sync_separator.sv
// Composite sync separator: pulse-width classification, line timer, lock tracking and burst gate.
module sync_separator
  import video_timing_pkg::*;
#(
  parameter int SYNC_THRESH  = DEF_SYNC_THRESH,
  parameter int HYST         = DEF_HYST,
  parameter int GLITCH_MIN   = DEF_GLITCH_MIN,
  parameter int HSYNC_MIN    = DEF_HSYNC_MIN,
  parameter int VSYNC_MIN    = DEF_VSYNC_MIN,
  parameter int LINE_MIN     = DEF_LINE_MIN,
  parameter int LINE_TIMEOUT = DEF_LINE_TIMEOUT,
  parameter int BURST_START  = NTSC_BURST_START,
  parameter int BURST_LEN    = NTSC_BURST_LEN,
  parameter int LOCK_LINES   = DEF_LOCK_LINES
) (
  input  logic            clk,
  input  logic            rst,
  sync_separator_if.slave bus
);

  localparam int GOOD_W = $clog2(LOCK_LINES + 1);
  // Reload so the timer counts from the raw leading edge, not from qualification.
  localparam logic [LINE_TMR_W-1:0] TMR_RELOAD   = LINE_TMR_W'(HSYNC_MIN + GLITCH_MIN + 1);
  localparam logic [LINE_TMR_W-1:0] TMR_MIN      = LINE_TMR_W'(LINE_MIN);
  localparam logic [LINE_TMR_W-1:0] TMR_TIMEOUT  = LINE_TMR_W'(LINE_TIMEOUT);
  localparam logic [LINE_TMR_W-1:0] TMR_BURST_LO = LINE_TMR_W'(BURST_START);
  localparam logic [LINE_TMR_W-1:0] TMR_BURST_HI = LINE_TMR_W'(BURST_START + BURST_LEN);
  localparam logic [LOW_CNT_W-1:0]  LOW_HSYNC    = LOW_CNT_W'(HSYNC_MIN);
  localparam logic [LOW_CNT_W-1:0]  LOW_VSYNC    = LOW_CNT_W'(VSYNC_MIN);
  localparam logic [LINE_CNT_W-1:0] BURST_CNT    = LINE_CNT_W'(BURST_MIN_LINE);
  localparam logic [LINE_CNT_W-1:0] REARM_CNT    = LINE_CNT_W'(VSYNC_REARM_LINE);
  localparam logic [GOOD_W-1:0]     GOOD_LOCK    = GOOD_W'(LOCK_LINES);

  logic                  sync_low;
  logic [LOW_CNT_W-1:0]  low_cnt_reg, low_cnt_next;
  logic [LINE_TMR_W-1:0] line_tmr_reg, line_tmr_next;
  logic [LINE_CNT_W-1:0] line_count_reg, line_count_next;
  logic [GOOD_W-1:0]     good_cnt_reg, good_cnt_next;
  logic                  v_armed_reg, v_armed_next;
  logic                  burst_reg, burst_next;
  logic                  locked, locked_next, in_window;
  sync_evt_t             evt;

  sync_slicer #(
    .SYNC_THRESH (SYNC_THRESH),
    .HYST        (HYST),
    .GLITCH_MIN  (GLITCH_MIN)
  ) u_slicer (
    .clk      (clk),
    .rst      (rst),
    .adc_raw  (bus.adc_raw),
    .sync_low (sync_low)
  );

  // Half-line serrations and equalising pulses only pass while unlocked or late in the line.
  always_comb begin
    locked      = (good_cnt_reg == GOOD_LOCK);
    in_window   = (line_tmr_reg >= TMR_MIN) && (line_tmr_reg <= TMR_TIMEOUT);
    evt.hsync   = (low_cnt_reg == LOW_HSYNC) && ((line_tmr_reg >= TMR_MIN) || !locked);
    evt.vsync   = (low_cnt_reg == LOW_VSYNC) && v_armed_reg;
    evt.timeout = (line_tmr_reg == TMR_TIMEOUT);
  end

  always_comb begin
    low_cnt_next = low_cnt_reg;
    if (!sync_low) begin
      low_cnt_next = '0;
    end else if (low_cnt_reg != '1) begin
      low_cnt_next = low_cnt_reg + 1'b1;
    end

    line_tmr_next = line_tmr_reg;
    if (evt.hsync) begin
      line_tmr_next = TMR_RELOAD;
    end else if (line_tmr_reg != '1) begin
      line_tmr_next = line_tmr_reg + 1'b1;
    end

    line_count_next = line_count_reg;
    if (evt.vsync) begin
      line_count_next = '0;
    end else if (evt.hsync && (line_count_reg != '1)) begin
      line_count_next = line_count_reg + 1'b1;
    end

    // An accepted hsync takes priority over a coincident timeout.
    good_cnt_next = good_cnt_reg;
    if (evt.hsync) begin
      if (!in_window) begin
        good_cnt_next = '0;
      end else if (good_cnt_reg != GOOD_LOCK) begin
        good_cnt_next = good_cnt_reg + 1'b1;
      end
    end else if (evt.timeout) begin
      good_cnt_next = '0;
    end

    v_armed_next = v_armed_reg;
    if (evt.vsync) begin
      v_armed_next = 1'b0;
    end else if (line_count_reg >= REARM_CNT) begin
      v_armed_next = 1'b1;
    end

    locked_next = (good_cnt_next == GOOD_LOCK);
    burst_next  = locked_next && (line_count_next >= BURST_CNT) &&
                  (line_tmr_next >= TMR_BURST_LO) && (line_tmr_next < TMR_BURST_HI) &&
                  !sync_low;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      low_cnt_reg    <= '0;
      line_tmr_reg   <= '0;
      line_count_reg <= '0;
      good_cnt_reg   <= '0;
      v_armed_reg    <= 1'b1;
      burst_reg      <= 1'b0;
    end else begin
      low_cnt_reg    <= low_cnt_next;
      line_tmr_reg   <= line_tmr_next;
      line_count_reg <= line_count_next;
      good_cnt_reg   <= good_cnt_next;
      v_armed_reg    <= v_armed_next;
      burst_reg      <= burst_next;
    end
  end

  assign bus.sync_low     = sync_low;
  assign bus.hsync_pulse  = evt.hsync;
  assign bus.vsync_pulse  = evt.vsync;
  assign bus.burst_active = burst_reg;
  assign bus.line_count   = line_count_reg;
  assign bus.locked       = locked;

endmodule

// File: tb/tb_sync_separator.sv
// Directed bench for sync_separator: ideal lines, spikes, reset, equalising, timeout, broad pulses.
`timescale 1ns/1ps
module tb_sync_separator;
  import video_timing_pkg::*;

  localparam sample_t TIP   = sample_t'(-2000);
  localparam sample_t BLANK = sample_t'(0);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Per-line observations, cycle offsets relative to the line's leading edge.
  int hs_n, hs_at, vs_n, vs_at, bu_n, bu_at, bu_last, sl_n, lk_first, lk_last, lc_end;

  sync_separator_if bus ();

  sync_separator dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one line (sync of low_len plus optional spike) and records what the outputs did.
  task automatic run_line(input int low_len, input int sp_at, input int sp_len, input int period);
    hs_n = 0; hs_at = -1; vs_n = 0; vs_at = -1; bu_n = 0; bu_at = -1; bu_last = -1;
    sl_n = 0; lk_first = -1; lk_last = -1; lc_end = -1;
    for (int k = 0; k < period; k++) begin
      bus.adc_raw = ((k < low_len) || (k >= sp_at && k < sp_at + sp_len)) ? TIP : BLANK;
      if (bus.hsync_pulse === 1'b1) begin hs_n++; if (hs_at < 0) hs_at = k; end
      if (bus.vsync_pulse === 1'b1) begin vs_n++; if (vs_at < 0) vs_at = k; end
      if (bus.burst_active === 1'b1) begin bu_n++; if (bu_at < 0) bu_at = k; bu_last = k; end
      if (bus.sync_low === 1'b1) sl_n++;
      if (bus.locked === 1'b1) begin if (lk_first < 0) lk_first = k; lk_last = k; end
      lc_end = int'(bus.line_count);
      tick();
    end
    $display("line low=%0d period=%0d hs=%0d@%0d vs=%0d@%0d burst=%0d[%0d..%0d] sl=%0d lock=[%0d..%0d] lc=%0d",
             low_len, period, hs_n, hs_at, vs_n, vs_at, bu_n, bu_at, bu_last, sl_n, lk_first, lk_last, lc_end);
  endtask

  task automatic test_reset();
    bus.adc_raw = BLANK;
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (bus.sync_low !== 1'b0) begin errors++; $display("FAIL reset_sync_low got %0b want 0", bus.sync_low); end
    checks++; if (bus.hsync_pulse !== 1'b0) begin errors++; $display("FAIL reset_hsync got %0b want 0", bus.hsync_pulse); end
    checks++; if (bus.vsync_pulse !== 1'b0) begin errors++; $display("FAIL reset_vsync got %0b want 0", bus.vsync_pulse); end
    checks++; if (bus.burst_active !== 1'b0) begin errors++; $display("FAIL reset_burst got %0b want 0", bus.burst_active); end
    checks++; if (bus.line_count !== 10'd0) begin errors++; $display("FAIL reset_line_count got %0d want 0", bus.line_count); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0b want 0", bus.locked); end
    rst = 1'b0;
    tick();
  endtask

  // Lines 1..8: hsync at 277, lock after the 4th in-window line (line 5), no burst below line 9.
  task automatic test_ideal_lines();
    int exp_first, exp_last;
    for (int i = 1; i <= 8; i++) begin
      run_line(349, 0, 0, 4719);
      exp_first = (i < 5) ? -1 : ((i == 5) ? 278 : 0);
      exp_last  = (i < 5) ? -1 : 4718;
      checks++; if (hs_n !== 1) begin errors++; $display("FAIL ideal_hs_count line %0d got %0d want 1", i, hs_n); end
      checks++; if (hs_at !== 277) begin errors++; $display("FAIL ideal_hs_at line %0d got %0d want 277", i, hs_at); end
      checks++; if (sl_n !== 349) begin errors++; $display("FAIL ideal_sync_low_len line %0d got %0d want 349", i, sl_n); end
      checks++; if (vs_n !== 0) begin errors++; $display("FAIL ideal_vsync line %0d got %0d want 0", i, vs_n); end
      checks++; if (bu_n !== 0) begin errors++; $display("FAIL ideal_burst_early line %0d got %0d want 0", i, bu_n); end
      checks++; if (lk_first !== exp_first) begin errors++; $display("FAIL ideal_lock_first line %0d got %0d want %0d", i, lk_first, exp_first); end
      checks++; if (lk_last !== exp_last) begin errors++; $display("FAIL ideal_lock_last line %0d got %0d want %0d", i, lk_last, exp_last); end
      checks++; if (lc_end !== i) begin errors++; $display("FAIL ideal_line_count line %0d got %0d want %0d", i, lc_end, i); end
    end
  endtask

  // Line 9 carries a 10-cycle spike mid-line; first line with burst enabled.
  task automatic test_spike_line();
    run_line(349, 2000, 10, 4719);
    checks++; if (hs_n !== 1) begin errors++; $display("FAIL spike_hs_count got %0d want 1", hs_n); end
    checks++; if (hs_at !== 277) begin errors++; $display("FAIL spike_hs_at got %0d want 277", hs_at); end
    checks++; if (sl_n !== 349) begin errors++; $display("FAIL spike_sync_low_len got %0d want 349", sl_n); end
    checks++; if (vs_n !== 0) begin errors++; $display("FAIL spike_vsync got %0d want 0", vs_n); end
    checks++; if (bu_at !== 401) begin errors++; $display("FAIL burst_start got %0d want 401", bu_at); end
    checks++; if (bu_last !== 580) begin errors++; $display("FAIL burst_end got %0d want 580", bu_last); end
    checks++; if (bu_n !== 180) begin errors++; $display("FAIL burst_len got %0d want 180", bu_n); end
    checks++; if (lc_end !== 9) begin errors++; $display("FAIL spike_line_count got %0d want 9", lc_end); end
  endtask

  task automatic test_reset_mid_burst();
    for (int k = 0; k < 500; k++) begin
      bus.adc_raw = (k < 349) ? TIP : BLANK;
      tick();
    end
    checks++; if (bus.burst_active !== 1'b1) begin errors++; $display("FAIL pre_reset_burst got %0b want 1", bus.burst_active); end
    checks++; if (bus.line_count !== 10'd10) begin errors++; $display("FAIL pre_reset_line_count got %0d want 10", bus.line_count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.burst_active !== 1'b0) begin errors++; $display("FAIL midrst_burst got %0b want 0", bus.burst_active); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL midrst_locked got %0b want 0", bus.locked); end
    checks++; if (bus.line_count !== 10'd0) begin errors++; $display("FAIL midrst_line_count got %0d want 0", bus.line_count); end
    checks++; if (bus.sync_low !== 1'b0) begin errors++; $display("FAIL midrst_sync_low got %0b want 0", bus.sync_low); end
    checks++; if (bus.hsync_pulse !== 1'b0) begin errors++; $display("FAIL midrst_hsync got %0b want 0", bus.hsync_pulse); end
    checks++; if (bus.vsync_pulse !== 1'b0) begin errors++; $display("FAIL midrst_vsync got %0b want 0", bus.vsync_pulse); end
  endtask

  // Two equalising pulses at half-line spacing while unlocked: never long enough to qualify.
  task automatic test_equalising();
    for (int i = 1; i <= 2; i++) begin
      run_line(171, 0, 0, 2360);
      checks++; if (hs_n !== 0) begin errors++; $display("FAIL eq_hsync pulse %0d got %0d want 0", i, hs_n); end
      checks++; if (sl_n !== 171) begin errors++; $display("FAIL eq_sync_low_len pulse %0d got %0d want 171", i, sl_n); end
    end
  endtask

  // Lines 1..3 after reset: in window but not yet locked.
  task automatic test_relock();
    for (int i = 1; i <= 3; i++) begin
      run_line(349, 0, 0, 4719);
      checks++; if (hs_at !== 277) begin errors++; $display("FAIL relock_hs_at line %0d got %0d want 277", i, hs_at); end
      checks++; if (lk_first !== -1) begin errors++; $display("FAIL relock_early_lock line %0d got %0d want -1", i, lk_first); end
      checks++; if (lc_end !== i) begin errors++; $display("FAIL relock_line_count line %0d got %0d want %0d", i, lc_end, i); end
    end
  endtask

  // 4th line relocks, then input stays at blank: locked drops when line_tmr hits 5200.
  task automatic test_timeout();
    run_line(349, 0, 0, 5300);
    checks++; if (lk_first !== 278) begin errors++; $display("FAIL relock_4th got %0d want 278", lk_first); end
    checks++; if (lk_last !== 5201) begin errors++; $display("FAIL timeout_unlock got %0d want 5201", lk_last); end
    checks++; if (bu_n !== 0) begin errors++; $display("FAIL timeout_burst got %0d want 0", bu_n); end
    checks++; if (bus.locked !== 1'b0) begin errors++; $display("FAIL timeout_locked_end got %0b want 0", bus.locked); end
  endtask

  // Six broad pulses: one vsync at 1517 in the first, line_count restarts from 0.
  task automatic test_vsync();
    int exp_vs;
    for (int b = 1; b <= 6; b++) begin
      run_line(2005, 0, 0, 2360);
      exp_vs = (b == 1) ? 1 : 0;
      checks++; if (hs_n !== 1) begin errors++; $display("FAIL broad_hs_count pulse %0d got %0d want 1", b, hs_n); end
      checks++; if (vs_n !== exp_vs) begin errors++; $display("FAIL broad_vs_count pulse %0d got %0d want %0d", b, vs_n, exp_vs); end
      checks++; if (lc_end !== b - 1) begin errors++; $display("FAIL broad_line_count pulse %0d got %0d want %0d", b, lc_end, b - 1); end
      checks++; if (bu_n !== 0) begin errors++; $display("FAIL broad_burst pulse %0d got %0d want 0", b, bu_n); end
      if (b == 1) begin
        checks++; if (vs_at !== 1517) begin errors++; $display("FAIL vsync_at got %0d want 1517", vs_at); end
      end
    end
  endtask

  initial begin
    bus.adc_raw = BLANK;
    test_reset();
    test_ideal_lines();
    test_spike_line();
    test_reset_mid_burst();
    test_equalising();
    test_relock();
    test_timeout();
    test_vsync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
